// File: rtl/i2c_write_master.sv
// i2c_write_master
//   Write-only I2C master. It pops {addr[6:0], data[7:0]} words from a
//   command FIFO and sends each one as START, address byte (R/W=0), ACK,
//   data byte, ACK, STOP. Each I2C bit is four quarters of CLK_DIV system
//   clocks, so a full transaction lasts 80*CLK_DIV cycles.
//
// Optional feature macro: I2C_ACK_CHECK_EN
//   When defined, a NACK sets the sticky ack_err flag (cleared only by arst)
//   and sends the FSM to STOP at the next bit boundary. When undefined, ACK
//   values are ignored and the ack_err port does not exist.
//
// Ports
//   clk        system clock, rising edge
//   arst       asynchronous active-high reset
//   fifo_empty command FIFO empty flag
//   fifo_data  FIFO head word, {addr[6:0], data[7:0]}
//   fifo_rd_en registered one-cycle pop strobe, high only in LOAD
//   scl_o      push-pull I2C clock
//   sda_oe     1 = pull SDA low, 0 = release SDA
//   sda_i      SDA line, already synchronised
//   busy       high from LOAD through the end of STOP
//   done       one-cycle pulse when a transaction ends
//   ack_err    sticky NACK flag (I2C_ACK_CHECK_EN only)
module i2c_write_master #(
  parameter int CLK_DIV    = 125,
  parameter int DATA_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  scl_o,
  output logic                  sda_oe,
  input  logic                  sda_i,
  output logic                  busy,
  output logic                  done
`ifdef I2C_ACK_CHECK_EN
  ,
  output logic                  ack_err
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD, START, ADDR, ACK1, DATA, ACK2, STOP} state_t;

  localparam int             TW        = $clog2(CLK_DIV);
  localparam logic [TW-1:0]  TIMER_MAX = TW'(CLK_DIV - 1);

  state_t          state, state_next;
  logic [TW-1:0]   timer;
  logic [1:0]      phase;      // q0..q3 within the current bit or START/STOP
  logic [2:0]      bit_cnt;
  logic [15:0]     shreg;      // {addr, R/W=0, data}, MSB on the wire next

  logic tick;                  // last system clock of a quarter
  logic q_end;                 // last system clock of a bit slot
  logic last_bit;
  logic is_bit_state;

  assign tick         = (timer == TIMER_MAX);
  assign q_end        = tick && (phase == 2'd3);
  assign last_bit     = (bit_cnt == 3'd7);
  assign is_bit_state = (state == ADDR) || (state == DATA);

`ifdef I2C_ACK_CHECK_EN
  logic nack_q;                // ACK bit sampled in the current ACK slot
`else
  // ACK values are ignored in this build; sda_i is intentionally unused.
  logic unused_sda;
  assign unused_sda = sda_i;
`endif

  // State register.
  always_ff @(posedge clk or posedge arst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (arst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state and output decode. Outputs depend only on registered state,
  // so a reset forces the bus to its released level immediately.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_next = state;
    scl_o      = 1'b1;
    sda_oe     = 1'b0;

    case (state)
      IDLE:  if (!fifo_empty) state_next = LOAD;
      LOAD:  state_next = START;
      START: begin
        sda_oe = phase[1];                 // SDA falls at q2 while SCL high
        if (q_end) state_next = ADDR;
      end
      ADDR: begin
        scl_o  = phase[1];
        sda_oe = ~shreg[15];
        if (q_end && last_bit) state_next = ACK1;
      end
      ACK1: begin
        scl_o = phase[1];
`ifdef I2C_ACK_CHECK_EN
        if (q_end) state_next = nack_q ? STOP : DATA;
`else
        if (q_end) state_next = DATA;
`endif
      end
      DATA: begin
        scl_o  = phase[1];
        sda_oe = ~shreg[15];
        if (q_end && last_bit) state_next = ACK2;
      end
      ACK2: begin
        scl_o = phase[1];
        if (q_end) state_next = STOP;
      end
      STOP: begin
        scl_o  = (phase != 2'd0);          // SCL low only in q0
        sda_oe = ~phase[1];                // SDA rises at q2 while SCL high
        if (q_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Quarter timer, phase, bit counter, shift register and strobes.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      timer      <= '0;
      phase      <= 2'd0;
      bit_cnt    <= 3'd0;
      shreg      <= '0;
      fifo_rd_en <= 1'b0;
      done       <= 1'b0;
    end else begin
      // Pop is decided from IDLE, so fifo_empty is never looked at while
      // the strobe is high.
      fifo_rd_en <= (state == IDLE) && !fifo_empty;
      done       <= (state == STOP) && q_end;

      if (state == IDLE || state == LOAD) begin
        timer   <= '0;
        phase   <= 2'd0;
        bit_cnt <= 3'd0;
      end else if (tick) begin
        timer <= '0;
        phase <= phase + 2'd1;
      end else begin
        timer <= timer + 1'b1;
      end

      if (is_bit_state && q_end) bit_cnt <= bit_cnt + 3'd1;

      // Shifting at the q3->q0 boundary makes sda_oe change only at q0 entry.
      if (state == LOAD)
        shreg <= {fifo_data[DATA_WIDTH-1 -: 7], 1'b0, fifo_data[7:0]};
      else if (is_bit_state && q_end)
        shreg <= {shreg[14:0], 1'b0};
    end
  end

`ifdef I2C_ACK_CHECK_EN
  // ACK sample at the end of q2, while SCL is high.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      nack_q  <= 1'b0;
      ack_err <= 1'b0;
    end else if ((state == ACK1 || state == ACK2) && tick && phase == 2'd2) begin
      nack_q <= sda_i;
      if (sda_i) ack_err <= 1'b1;
    end
  end
`endif

endmodule
